lsu_ctrl: RTL and testbench

Load/store control stage directly upstream of the byte-addressed data memory. Accepts one load/store request at a time from the CPU datapath over a valid/ready handshake and classifies it as aligned, misaligned, illegal or out of range. Aligned accesses are driven onto the memory port in a single cycle; misaligned accesses are split into byte accesses. Returns a one-cycle response pulse carrying load data or an error.

---
 rtl/lsu_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the byte-addressed data memory.
// Classifies each request as illegal, out of range, misaligned or aligned,
// then performs one memory access, splits it into byte accesses, or reports
// an error.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (split misaligned w/h/hu
// accesses into byte accesses; when undefined they are errors).
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_ls,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_ls,
  input  logic [31:0] mem_dout
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

  localparam logic [3:0] LS_W  = 4'b0000;
  localparam logic [3:0] LS_H  = 4'b1000;
  localparam logic [3:0] LS_B  = 4'b0100;
  localparam logic [3:0] LS_HU = 4'b0010;
  localparam logic [3:0] LS_BU = 4'b0001;

  state_t      state_q, state_d;
  logic        we_q;
  logic [3:0]  ls_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        known, illegal, oor, misal;
  logic [2:0]  size;
  logic [32:0] end_addr;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]  idx_q;
  logic [31:0] asm_q, asm_next;
  logic        last_byte;
`endif

  assign accept     = req_valid && (state_q == IDLE);
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  // Classify the incoming request; range check in 33 bits so it cannot wrap
  always_comb begin
    known = 1'b1;
    size  = 3'd1;
    case (req_ls)
      LS_W:        size = 3'd4;
      LS_H, LS_HU: size = 3'd2;
      LS_B, LS_BU: size = 3'd1;
      default:     known = 1'b0;
    endcase
    illegal  = !known || (req_we && ((req_ls == LS_HU) || (req_ls == LS_BU)));
    end_addr = {1'b0, req_addr} + 33'(size) - 33'd1;
    oor      = end_addr >= 33'(MEM_BYTES);
    misal    = ((req_ls == LS_W) && (req_addr[1:0] != 2'b00)) ||
               (((req_ls == LS_H) || (req_ls == LS_HU)) && req_addr[0]);
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Merge the byte arriving this cycle into the assembly buffer
  always_comb begin
    asm_next = asm_q;
    asm_next[{idx_q, 3'b000} +: 8] = mem_dout[7:0];
    last_byte = (ls_q == LS_W) ? (idx_q == 2'd3) : (idx_q == 2'd1);
  end
`endif

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal || oor) begin
            state_d = RESP;
          end else if (misal) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state_d = SPLIT;
`else
            state_d = RESP;
`endif
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: state_d = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
      SPLIT:  if (last_byte) state_d = RESP;
`endif
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port drive; idle value is all zeros
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    mem_ls   = 4'b0000;
    case (state_q)
      ACCESS: begin
        mem_we   = we_q;
        mem_addr = addr_q;
        mem_din  = wdata_q;
        mem_ls   = ls_q;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      SPLIT: begin
        mem_we   = we_q;
        mem_addr = addr_q + {30'b0, idx_q};
        mem_din  = {24'b0, wdata_q[{idx_q, 3'b000} +: 8]};
        mem_ls   = we_q ? LS_B : LS_BU;
      end
`endif
      default: ;
    endcase
  end

  // State, request latches and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      ls_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      idx_q     <= '0;
      asm_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            ls_q    <= req_ls;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            idx_q   <= '0;
            asm_q   <= '0;
            if (illegal || oor) begin
`else
            if (illegal || oor || misal) begin
`endif
              resp_data <= '0;
              resp_err  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          resp_err  <= 1'b0;
          resp_data <= we_q ? '0 : mem_dout;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        SPLIT: begin
          if (!we_q) asm_q <= asm_next;
          idx_q <= idx_q + 2'd1;
          if (last_byte) begin
            resp_err <= 1'b0;
            if (we_q)                resp_data <= '0;
            else if (ls_q == LS_W)   resp_data <= asm_next;
            else if (ls_q == LS_H)   resp_data <= {{16{asm_next[15]}}, asm_next[15:0]};
            else                     resp_data <= {16'b0, asm_next[15:0]};
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-array memory model that applies
// sign/zero extension on reads, as the real data memory does.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_ls = 4'b0000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_ls;
  logic [31:0] mem_dout;

  int nerr = 0;
  int nchk = 0;

  lsu_ctrl #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ls(req_ls), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ls(mem_ls), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [7:0] mem [0:1023];
  logic [9:0] ma;
  assign ma = mem_addr[9:0];

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_ls)
        4'b0000: begin
          mem[ma] <= mem_din[7:0];          mem[ma + 10'd1] <= mem_din[15:8];
          mem[ma + 10'd2] <= mem_din[23:16]; mem[ma + 10'd3] <= mem_din[31:24];
        end
        4'b1000, 4'b0010: begin
          mem[ma] <= mem_din[7:0]; mem[ma + 10'd1] <= mem_din[15:8];
        end
        default: mem[ma] <= mem_din[7:0];
      endcase
    end
  end

  always_comb begin
    mem_dout = '0;
    case (mem_ls)
      4'b0000: mem_dout = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
      4'b1000: mem_dout = {{16{mem[ma + 10'd1][7]}}, mem[ma + 10'd1], mem[ma]};
      4'b0010: mem_dout = {16'b0, mem[ma + 10'd1], mem[ma]};
      4'b0100: mem_dout = {{24{mem[ma][7]}}, mem[ma]};
      4'b0001: mem_dout = {24'b0, mem[ma]};
      default: mem_dout = '0;
    endcase
  end

  typedef struct {
    logic        we;
    logic [3:0]  ls;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        eerr;
    logic [31:0] edata;
    int          elat;
    int          ewr;
    int          eacc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request and check latency, response and memory activity
  task automatic do_req(input vec_t v, input string nm);
    int  lat = 0;
    int  wr = 0;
    int  acc = 0;
    bit  seen = 0;
    @(negedge clk);
    chk({nm, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_ls = v.ls;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_we) wr++;
      if (mem_we || mem_addr != 0 || mem_ls != 4'b0000) acc++;
      if (resp_valid) begin
        seen = 1;
        lat = c;
      end
    end
    if (!seen) begin
      nchk++; nerr++;
      $display("FAIL %s.timeout: got no resp_valid expected resp within 20 cycles", nm);
    end else begin
      chk({nm, ".lat"}, 32'(lat), 32'(v.elat));
      chk({nm, ".err"}, 32'(resp_err), 32'(v.eerr));
      chk({nm, ".data"}, resp_data, v.edata);
      chk({nm, ".wr"}, 32'(wr), 32'(v.ewr));
      chk({nm, ".acc"}, 32'(acc), 32'(v.eacc));
      @(negedge clk);
      chk({nm, ".pulse"}, 32'(resp_valid), 32'd0);
      chk({nm, ".hold"}, resp_data, v.edata);
    end
  endtask

  initial begin
    //           we    ls       addr           wdata          err   data           lat wr acc
    vecs.push_back('{1'b1, 4'b0000, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,         2, 1, 1});
    vecs.push_back('{1'b0, 4'b0000, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF,  2, 0, 1});
    vecs.push_back('{1'b1, 4'b0010, 32'h0,        32'h1234,     1'b1, 32'h0,         1, 0, 0});
    vecs.push_back('{1'b0, 4'b0000, 32'h3FE,      32'h0,        1'b1, 32'h0,         1, 0, 0});
    vecs.push_back('{1'b1, 4'b0000, 32'h3FC,      32'hCAFEF00D, 1'b0, 32'h0,         2, 1, 1});
    vecs.push_back('{1'b0, 4'b0000, 32'h3FC,      32'h0,        1'b0, 32'hCAFEF00D,  2, 0, 1});
    vecs.push_back('{1'b1, 4'b0100, 32'h3FF,      32'h123456A5, 1'b0, 32'h0,         2, 1, 1});
    vecs.push_back('{1'b0, 4'b0100, 32'h3FF,      32'h0,        1'b0, 32'hFFFFFFA5,  2, 0, 1});
    vecs.push_back('{1'b0, 4'b0001, 32'h3FF,      32'h0,        1'b0, 32'h000000A5,  2, 0, 1});
    vecs.push_back('{1'b1, 4'b1000, 32'h3FF,      32'h1234,     1'b1, 32'h0,         1, 0, 0});
    vecs.push_back('{1'b0, 4'b1111, 32'h10,       32'h0,        1'b1, 32'h0,         1, 0, 0});
    vecs.push_back('{1'b0, 4'b0100, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,         1, 0, 0});
    vecs.push_back('{1'b1, 4'b0001, 32'h10,       32'hFF,       1'b1, 32'h0,         1, 0, 0});
    vecs.push_back('{1'b1, 4'b1000, 32'h20,       32'h000080FF, 1'b0, 32'h0,         2, 1, 1});
    vecs.push_back('{1'b0, 4'b1000, 32'h20,       32'h0,        1'b0, 32'hFFFF80FF,  2, 0, 1});
    vecs.push_back('{1'b0, 4'b0010, 32'h20,       32'h0,        1'b0, 32'h000080FF,  2, 0, 1});
    vecs.push_back('{1'b0, 4'b1000, 32'h3FF,      32'h0,        1'b1, 32'h0,         1, 0, 0});
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back('{1'b1, 4'b0000, 32'h5,        32'h11223344, 1'b0, 32'h0,         5, 4, 4});
    vecs.push_back('{1'b0, 4'b0000, 32'h5,        32'h0,        1'b0, 32'h11223344,  5, 0, 4});
    vecs.push_back('{1'b1, 4'b1000, 32'h3,        32'h000080FF, 1'b0, 32'h0,         3, 2, 2});
    vecs.push_back('{1'b0, 4'b1000, 32'h3,        32'h0,        1'b0, 32'hFFFF80FF,  3, 0, 2});
    vecs.push_back('{1'b0, 4'b0010, 32'h3,        32'h0,        1'b0, 32'h000080FF,  3, 0, 2});
`else
    vecs.push_back('{1'b0, 4'b0000, 32'h5,        32'h0,        1'b1, 32'h0,         1, 0, 0});
    vecs.push_back('{1'b1, 4'b1000, 32'h3,        32'h000080FF, 1'b1, 32'h0,         1, 0, 0});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.rvalid", 32'(resp_valid), 32'd0);
    chk("rst.rerr", 32'(resp_err), 32'd0);
    chk("rst.rdata", resp_data, 32'd0);
    chk("rst.mwe", 32'(mem_we), 32'd0);
    chk("rst.maddr", mem_addr, 32'd0);
    chk("rst.mdin", mem_din, 32'd0);
    chk("rst.mls", 32'(mem_ls), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) do_req(vecs[i], $sformatf("v%0d", i));

`ifdef LSU_MISALIGN_SPLIT_EN
    chk("split.m5", 32'(mem[5]), 32'h44);
    chk("split.m6", 32'(mem[6]), 32'h33);
    chk("split.m7", 32'(mem[7]), 32'h22);
    chk("split.m8", 32'(mem[8]), 32'h11);

    // Reset during idx=2 of a split word store at 0x1
    do_req('{1'b1, 4'b0100, 32'h3, 32'hEE, 1'b0, 32'h0, 2, 1, 1}, "pre3");
    do_req('{1'b1, 4'b0100, 32'h4, 32'hEE, 1'b0, 32'h0, 2, 1, 1}, "pre4");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_ls = 4'b0000;
    req_addr = 32'h1; req_wdata = 32'hA1B2C3D4;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort.idx0", mem_addr, 32'h1);
    @(negedge clk);
    chk("abort.idx1", mem_addr, 32'h2);
    @(negedge clk);
    chk("abort.idx2", mem_addr, 32'h3);
    rst = 1'b1;
    #1;
    chk("abort.ready", 32'(req_ready), 32'd1);
    chk("abort.mwe", 32'(mem_we), 32'd0);
    chk("abort.maddr", mem_addr, 32'd0);
    chk("abort.mls", 32'(mem_ls), 32'd0);
    chk("abort.rvalid", 32'(resp_valid), 32'd0);
    chk("abort.rdata", resp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort.m1", 32'(mem[1]), 32'hD4);
    chk("abort.m2", 32'(mem[2]), 32'hC3);
    chk("abort.m3", 32'(mem[3]), 32'hEE);
    chk("abort.m4", 32'(mem[4]), 32'hEE);
    do_req('{1'b0, 4'b0000, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 0, 1}, "post");
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
